// File: rtl/pic_prio_pkg.sv
// Shared trigger-mode encodings and the per-source event decode for pic_prio.
package pic_prio_pkg;

    localparam int TRG_W = 3;

    // Bit 2 selects edge (1) or level (0). For TRG_BOTH, bit 0 is a don't-care.
    typedef enum logic [TRG_W-1:0] {
        TRG_LVL_HI = 3'b000,
        TRG_LVL_LO = 3'b001,
        TRG_RISE   = 3'b100,
        TRG_FALL   = 3'b101,
        TRG_BOTH   = 3'b110
    } trg_e;

    // cur is the first synchroniser stage and prev is the second stage.
    // The level result is taken from cur because it is loaded into the event
    // flop on the same edge that cur moves into the second stage. The
    // registered event therefore tracks the second stage exactly.
    function automatic logic trigger(input logic [TRG_W-1:0] trg,
                                     input logic cur,
                                     input logic prev);
        logic rise;
        logic fall;
        logic res;
        rise = cur & ~prev;
        fall = ~cur & prev;
        if (trg[2]) begin
            if (trg[1]) res = rise | fall;
            else        res = trg[0] ? fall : rise;
        end else begin
            res = trg[0] ? ~cur : cur;
        end
        return res;
    endfunction

endpackage

// File: rtl/pic_prio_if.sv
// CPU/config side bundle of the priority interrupt controller.
interface pic_prio_if #(
    parameter int NUM_SRC = 16,
    parameter int PRIO_W  = 3,
    parameter int ID_W    = $clog2(NUM_SRC)
);
    logic [NUM_SRC-1:0]        src_int;
    logic [3*NUM_SRC-1:0]      int_trg;
    logic [NUM_SRC-1:0]        int_msk;
    logic [PRIO_W*NUM_SRC-1:0] int_prio;
    logic [PRIO_W-1:0]         prio_thr;
    logic                      int_clr_en;
    logic [NUM_SRC-1:0]        clr_ints;
    logic                      claim;
    logic                      complete;
    logic [ID_W-1:0]           complete_id;
    logic [NUM_SRC-1:0]        int_sta;
    logic [NUM_SRC-1:0]        int_isv;
    logic                      out_int;
    logic [ID_W-1:0]           out_id;
    logic [PRIO_W-1:0]         out_prio;

    modport master (
        output src_int, int_trg, int_msk, int_prio, prio_thr,
               int_clr_en, clr_ints, claim, complete, complete_id,
        input  int_sta, int_isv, out_int, out_id, out_prio
    );

    modport slave (
        input  src_int, int_trg, int_msk, int_prio, prio_thr,
               int_clr_en, clr_ints, claim, complete, complete_id,
        output int_sta, int_isv, out_int, out_id, out_prio
    );
endinterface

// File: rtl/pic_prio_arb.sv
// Combinational tournament tree: the highest priority among eligible sources
// wins. On equal priority the left branch wins, which is the lower index.
module pic_prio_arb
    import pic_prio_pkg::*;
#(
    parameter int NUM_SRC = 16,
    parameter int PRIO_W  = 3,
    parameter int ID_W    = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0]        el_i,
    input  logic [PRIO_W*NUM_SRC-1:0] prio_i,
    output logic                      valid_o,
    output logic [ID_W-1:0]           id_o,
    output logic [PRIO_W-1:0]         prio_o
);
    localparam int LEAVES = 1 << $clog2(NUM_SRC);
    localparam int NODES  = 2 * LEAVES - 1;

    // Pad to a power of two so that every internal node has two children.
    logic [LEAVES-1:0]        el_pad;
    logic [PRIO_W*LEAVES-1:0] prio_pad;
    logic                     node_v  [NODES];
    logic [ID_W-1:0]          node_id [NODES];
    logic [PRIO_W-1:0]        node_p  [NODES];

    assign el_pad   = LEAVES'(el_i);
    assign prio_pad = (PRIO_W*LEAVES)'(prio_i);

    // Heap-ordered tree. Leaves are filled first, then each parent is reduced
    // from its two children, working from the bottom of the tree upwards.
    always_comb begin
        for (int i = 0; i < LEAVES; i++) begin
            node_v[LEAVES-1+i]  = el_pad[i];
            node_id[LEAVES-1+i] = ID_W'(i);
            node_p[LEAVES-1+i]  = prio_pad[PRIO_W*i +: PRIO_W];
        end
        for (int i = LEAVES - 2; i >= 0; i--) begin
            if (node_v[2*i+2] && (!node_v[2*i+1] || (node_p[2*i+2] > node_p[2*i+1]))) begin
                node_id[i] = node_id[2*i+2];
                node_p[i]  = node_p[2*i+2];
            end else begin
                node_id[i] = node_id[2*i+1];
                node_p[i]  = node_p[2*i+1];
            end
            node_v[i] = node_v[2*i+1] | node_v[2*i+2];
        end
        valid_o = node_v[0];
        id_o    = node_id[0];
        prio_o  = node_p[0];
    end
endmodule

// File: rtl/pic_prio.sv
// Priority interrupt controller. It synchronises the sources, decodes events,
// latches the pending status and tracks in-service sources. It registers the
// winner of the priority arbitration for the CPU.
module pic_prio
    import pic_prio_pkg::*;
#(
    parameter int NUM_SRC = 16,
    parameter int PRIO_W  = 3,
    parameter int ID_W    = $clog2(NUM_SRC)
) (
    input  logic      pclk,
    input  logic      presetn,
    pic_prio_if.slave bus
);
    logic [NUM_SRC-1:0] sync1_q, sync2_q;
    logic [NUM_SRC-1:0] evt_q, evt_d;
    logic [NUM_SRC-1:0] sta_q, sta_d;
    logic [NUM_SRC-1:0] isv_q, isv_d;
    logic               out_int_q, out_int_d;
    logic [ID_W-1:0]    out_id_q, out_id_d;
    logic [PRIO_W-1:0]  out_prio_q, out_prio_d;

    logic [NUM_SRC-1:0] clr_mask, claim_mask, cmpl_mask, el;
    logic               claim_ok;
    logic               arb_valid;
    logic [ID_W-1:0]    arb_id;
    logic [PRIO_W-1:0]  arb_prio;

    // A claim is accepted only while a request is being presented.
    assign claim_ok = bus.claim & out_int_q;

    // Per-source event decode, status and in-service updates, and eligibility.
    always_comb begin
        evt_d      = '0;
        claim_mask = '0;
        cmpl_mask  = '0;
        el         = '0;
        for (int n = 0; n < NUM_SRC; n++) begin
            evt_d[n]      = trigger(bus.int_trg[TRG_W*n +: TRG_W], sync1_q[n], sync2_q[n]);
            claim_mask[n] = claim_ok && (out_id_q == ID_W'(n));
            cmpl_mask[n]  = bus.complete && (bus.complete_id == ID_W'(n));
            el[n]         = sta_q[n] & ~bus.int_msk[n] & ~isv_q[n]
                          & (bus.int_prio[PRIO_W*n +: PRIO_W] > bus.prio_thr);
        end
        clr_mask = bus.int_clr_en ? bus.clr_ints : '0;
        // The event term is ORed in last, so a new event wins over a clear or claim.
        sta_d    = (sta_q & ~clr_mask & ~claim_mask) | evt_q;
        // The claim term is ORed in last, so it wins over a same-cycle complete.
        isv_d    = (isv_q & ~cmpl_mask) | claim_mask;
    end

    pic_prio_arb #(
        .NUM_SRC (NUM_SRC),
        .PRIO_W  (PRIO_W),
        .ID_W    (ID_W)
    ) u_arb (
        .el_i    (el),
        .prio_i  (bus.int_prio),
        .valid_o (arb_valid),
        .id_o    (arb_id),
        .prio_o  (arb_prio)
    );

    // Output selection. The claim cycle drops the request so that the claimed
    // ID is not shown again. Arbitration resumes on the updated state one cycle later.
    always_comb begin
        out_int_d  = 1'b0;
        out_id_d   = out_id_q;
        out_prio_d = out_prio_q;
        if (!claim_ok && arb_valid) begin
            out_int_d  = 1'b1;
            out_id_d   = arb_id;
            out_prio_d = arb_prio;
        end
    end

    // Synchronisers, event, status and in-service registers.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            sync1_q <= '0;
            sync2_q <= '0;
            evt_q   <= '0;
            sta_q   <= '0;
            isv_q   <= '0;
        end else begin
            sync1_q <= bus.src_int;
            sync2_q <= sync1_q;
            evt_q   <= evt_d;
            sta_q   <= sta_d;
            isv_q   <= isv_d;
        end
    end

    // Registered request, ID and priority to the CPU.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            out_int_q  <= 1'b0;
            out_id_q   <= '0;
            out_prio_q <= '0;
        end else begin
            out_int_q  <= out_int_d;
            out_id_q   <= out_id_d;
            out_prio_q <= out_prio_d;
        end
    end

    assign bus.int_sta  = sta_q;
    assign bus.int_isv  = isv_q;
    assign bus.out_int  = out_int_q;
    assign bus.out_id   = out_id_q;
    assign bus.out_prio = out_prio_q;
endmodule

// File: tb/tb_pic_prio.sv
// Directed scenarios followed by a randomized run. Every cycle is compared
// against a behavioural model of the controller.
module tb_pic_prio;
    import pic_prio_pkg::*;

    localparam int NS = 16;
    localparam int PW = 3;
    localparam int IW = 4;

    logic pclk    = 1'b0;
    logic presetn = 1'b1;
    int   n_cmp   = 0;
    int   n_err   = 0;

    pic_prio_if #(.NUM_SRC(NS), .PRIO_W(PW), .ID_W(IW)) bus();

    pic_prio #(.NUM_SRC(NS), .PRIO_W(PW), .ID_W(IW)) dut (
        .pclk    (pclk),
        .presetn (presetn),
        .bus     (bus)
    );

    always #5 pclk = ~pclk;

    // Model state.
    // m_h1 holds src at the last edge and m_h2 holds src one edge earlier.
    logic [NS-1:0] m_h1, m_h2, m_ev, m_sta, m_isv;
    logic          m_int;
    logic [IW-1:0] m_id;
    logic [PW-1:0] m_prio;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_h1 = '0; m_h2 = '0; m_ev = '0; m_sta = '0; m_isv = '0;
        m_int = 1'b0; m_id = '0; m_prio = '0;
    endtask

    // Advance the model by one clock edge, using the inputs as they stand now.
    task automatic step();
        logic [NS-1:0] ev, clr, clm, cmp;
        logic [2:0]    t;
        logic [PW-1:0] pr, best_p;
        logic          now, was;
        int            best;
        ev = '0;
        for (int n = 0; n < NS; n++) begin
            t   = bus.int_trg[3*n +: 3];
            now = m_h1[n];
            was = m_h2[n];
            if (!t[2])     ev[n] = t[0] ? ~now : now;
            else if (t[1]) ev[n] = now ^ was;
            else if (t[0]) ev[n] = was & ~now;
            else           ev[n] = now & ~was;
        end
        clr = bus.int_clr_en ? bus.clr_ints : '0;
        clm = '0;
        if (bus.claim && m_int) clm[m_id] = 1'b1;
        cmp = '0;
        if (bus.complete) cmp[bus.complete_id] = 1'b1;
        best   = -1;
        best_p = bus.prio_thr;
        for (int n = 0; n < NS; n++) begin
            pr = bus.int_prio[PW*n +: PW];
            if (m_sta[n] && !bus.int_msk[n] && !m_isv[n] && pr > best_p) begin
                best   = n;
                best_p = pr;
            end
        end
        m_sta = (m_sta & ~clr & ~clm) | m_ev;
        m_isv = (m_isv & ~cmp) | clm;
        m_ev  = ev;
        m_h2  = m_h1;
        m_h1  = bus.src_int;
        if (bus.claim && m_int) m_int = 1'b0;
        else if (best >= 0) begin
            m_int  = 1'b1;
            m_id   = IW'(best);
            m_prio = best_p;
        end else m_int = 1'b0;
    endtask

    task automatic compare_all();
        check("out_int",  bus.out_int,  m_int);
        check("out_id",   bus.out_id,   m_id);
        check("out_prio", bus.out_prio, m_prio);
        check("int_sta",  bus.int_sta,  m_sta);
        check("int_isv",  bus.int_isv,  m_isv);
    endtask

    task automatic cyc();
        step();
        @(posedge pclk);
        #1;
        compare_all();
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_int"},  bus.out_int,  0);
        check({tag, "_id"},   bus.out_id,   0);
        check({tag, "_prio"}, bus.out_prio, 0);
        check({tag, "_sta"},  bus.int_sta,  0);
        check({tag, "_isv"},  bus.int_isv,  0);
    endtask

    task automatic do_reset();
        presetn = 1'b0;
        model_reset();
        repeat (2) @(posedge pclk);
        #1;
        check_zero("in_rst");
        presetn = 1'b1;
    endtask

    task automatic quiet();
        bus.claim = 1'b0; bus.complete = 1'b0; bus.complete_id = '0;
        bus.int_clr_en = 1'b0; bus.clr_ints = '0;
    endtask

    task automatic rand_cfg();
        bus.int_trg  = 48'({$urandom(), $urandom()});
        bus.int_prio = 48'({$urandom(), $urandom()});
        bus.prio_thr = PW'($urandom_range(0, 3));
        bus.int_msk  = NS'($urandom() & $urandom());
    endtask

    initial begin
        logic done;
        quiet();
        // Reset while all sources are active with level-high trigger and priority 1.
        bus.src_int = '1; bus.int_trg = '0; bus.int_msk = '0;
        bus.int_prio = {NS{3'd1}}; bus.prio_thr = '0;
        do_reset();
        repeat (3) cyc();
        cyc();
        check("rel_int", bus.out_int, 1);
        check("rel_id",  bus.out_id,  0);

        // Two rising edges arrive together. Source 9 wins, then source 3 follows the claim.
        bus.src_int = '0; bus.int_trg = '0; bus.int_prio = '0;
        bus.int_trg[3*3 +: 3] = TRG_RISE; bus.int_trg[3*9 +: 3] = TRG_RISE;
        bus.int_prio[PW*3 +: PW] = 3'd2; bus.int_prio[PW*9 +: PW] = 3'd5;
        do_reset();
        repeat (3) cyc();
        bus.src_int[3] = 1'b1; bus.src_int[9] = 1'b1;
        repeat (4) cyc();
        check("two_id",   bus.out_id,   9);
        check("two_prio", bus.out_prio, 5);
        bus.claim = 1'b1; cyc(); bus.claim = 1'b0;
        cyc();
        check("after_claim_id", bus.out_id, 3);
        check("after_claim_isv", bus.int_isv, 16'h0200);
        bus.complete = 1'b1; bus.complete_id = 4'd9; cyc(); quiet();
        repeat (2) cyc();
        check("edge_consumed", bus.int_sta[9], 0);
        check("still_3", bus.out_id, 3);

        // Equal priority resolves to the lower index. Masking switches the winner.
        bus.src_int = 16'h0090; bus.int_trg = '0; bus.int_prio = '0;
        bus.int_prio[PW*4 +: PW] = 3'd6; bus.int_prio[PW*7 +: PW] = 3'd6;
        do_reset();
        repeat (4) cyc();
        check("tie_id", bus.out_id, 4);
        bus.int_msk[4] = 1'b1; cyc();
        check("mask_id", bus.out_id, 7);
        bus.int_msk = '0;

        // Threshold boundary: a priority equal to the threshold is not delivered.
        bus.src_int = 16'h0004; bus.int_prio = '0; bus.int_prio[PW*2 +: PW] = 3'd5;
        bus.prio_thr = 3'd5;
        do_reset();
        repeat (5) cyc();
        check("thr_eq_int", bus.out_int, 0);
        bus.prio_thr = 3'd4; cyc();
        check("thr_lo_int", bus.out_int, 1);
        check("thr_lo_id",  bus.out_id,  2);
        bus.prio_thr = '0;

        // Both-edge source with a 3-cycle pulse. An event in the same cycle as a clear wins.
        bus.src_int = '0; bus.int_trg = '0; bus.int_trg[3*5 +: 3] = TRG_BOTH;
        bus.int_prio = '0; bus.int_prio[PW*5 +: PW] = 3'd3;
        do_reset();
        repeat (2) cyc();
        bus.src_int[5] = 1'b1; repeat (3) cyc(); bus.src_int[5] = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (!done && m_ev[5] && m_sta[5]) begin
                bus.int_clr_en = 1'b1; bus.clr_ints = 16'h0020;
                cyc(); quiet();
                check("set_wins", bus.int_sta[5], 1);
                done = 1'b1;
            end else cyc();
        end
        check("set_wins_reached", done, 1);
        bus.clr_ints = 16'h0020; cyc();
        check("clr_no_en", bus.int_sta[5], 1);
        bus.int_clr_en = 1'b1; cyc(); quiet();
        check("clr_en", bus.int_sta[5], 0);

        // A level source held active is excluded while in service and re-pends after complete.
        bus.src_int = 16'h0040; bus.int_trg = '0; bus.int_prio = '0;
        bus.int_prio[PW*6 +: PW] = 3'd4;
        do_reset();
        repeat (4) cyc();
        check("lvl_id", bus.out_id, 6);
        bus.claim = 1'b1; cyc(); bus.claim = 1'b0;
        cyc();
        check("isv6", bus.int_isv[6], 1);
        check("isv6_excl", bus.out_int, 0);
        bus.complete = 1'b1; bus.complete_id = 4'd6; cyc(); quiet();
        cyc();
        check("repend_int", bus.out_int, 1);
        check("repend_id",  bus.out_id,  6);

        // Randomized traffic, with one asynchronous reset in the middle.
        rand_cfg();
        bus.src_int = NS'($urandom());
        do_reset();
        for (int c = 0; c < 600; c++) begin
            if (c % 60 == 0) rand_cfg();
            bus.src_int    = bus.src_int ^ NS'($urandom() & $urandom() & $urandom());
            bus.claim      = ($urandom_range(0, 3) == 0);
            bus.complete   = ($urandom_range(0, 2) == 0);
            bus.complete_id = IW'($urandom());
            bus.int_clr_en = 1'($urandom_range(0, 1));
            bus.clr_ints   = NS'($urandom() & $urandom());
            if (c == 300) begin
                #2 presetn = 1'b0;
                #1 check_zero("async_rst");
                model_reset();
                @(posedge pclk);
                #3 presetn = 1'b1;
            end
            cyc();
        end
        quiet();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
